// File: rtl/serial_adder_ctrl_if.sv
// Request/result handshake bundle for the bit-serial adder sequencer.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  // Requester/consumer side
  modport master (
    output start_valid, a_in, b_in, cin, res_ready,
    input  start_ready, res_valid, sum_out, cout
  );

  // Controller side
  modport slave (
    input  start_valid, a_in, b_in, cin, res_ready,
    output start_ready, res_valid, sum_out, cout
  );

endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice (two half adders + OR)
// iterated LSB-first for WIDTH cycles, with valid/ready request and result.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus,
  output logic                busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;

  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic             w_ha0_s;
  logic             w_ha0_c;
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_s;
  logic             w_c;

  // One-bit adder slice built from two half adders and an OR for carry
  always_comb begin
    w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
    w_ha0_c = r_a_sh[0] & r_b_sh[0];
    w_ha1_s = w_ha0_s ^ r_carry;
    w_ha1_c = w_ha0_s & r_carry;
    w_s     = w_ha1_s;
    w_c     = w_ha0_c | w_ha1_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_valid) begin
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture, serial shift and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_bit_cnt <= '0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
    end else if (w_load) begin
      r_a_sh    <= bus.a_in;
      r_b_sh    <= bus.b_in;
      r_carry   <= bus.cin;
      r_bit_cnt <= '0;
    end else if (w_step) begin
      r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry  <= w_c;
      if (w_last) begin
        // Counter parks at zero rather than wrapping past the last bit
        r_bit_cnt <= '0;
        r_sum_out <= {w_s, r_sum_sh[WIDTH-1:1]};
        r_cout    <= w_c;
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // Handshake flags decoded from the state register
  assign bus.start_ready = (r_state == S_IDLE);
  assign bus.res_valid   = (r_state == S_DONE);
  assign bus.sum_out     = r_sum_out;
  assign bus.cout        = r_cout;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases plus random operands checked
// against plain-arithmetic addition.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles of res_ready=0 in DONE, pulse = stray start_valid
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input int hold, input bit pulse, input string tag);
    logic [8:0] exp;
    int         n;
    bit         seen;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    chk({tag, " start_ready idle"}, 64'(bus_if.start_ready), 64'd1);
    bus_if.start_valid = 1'b1;
    bus_if.a_in        = a;
    bus_if.b_in        = b;
    bus_if.cin         = ci;
    bus_if.res_ready   = (hold == 0);
    tick();
    bus_if.start_valid = 1'b0;
    bus_if.a_in        = 8'($urandom);
    bus_if.b_in        = 8'($urandom);
    bus_if.cin         = 1'($urandom);
    chk({tag, " busy after accept"}, 64'(busy), 64'd1);
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 3 * int'(WIDTH) && !seen; i++) begin
      if (pulse && i == 3) begin
        bus_if.start_valid = 1'b1;
        bus_if.a_in        = 8'h01;
      end
      tick();
      if (pulse && i == 3) bus_if.start_valid = 1'b0;
      if (bus_if.res_valid) begin
        seen = 1'b1;
        n    = i;
      end
    end
    chk({tag, " latency edges"}, 64'(n), 64'(WIDTH));
    if (seen) begin
      chk({tag, " sum_out"}, 64'(bus_if.sum_out), 64'(exp[7:0]));
      chk({tag, " cout"}, 64'(bus_if.cout), 64'(exp[8]));
      chk({tag, " start_ready in done"}, 64'(bus_if.start_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
        if (pulse && h == 0) begin
          bus_if.start_valid = 1'b1;
          bus_if.a_in        = 8'h01;
        end
        tick();
        bus_if.start_valid = 1'b0;
        chk({tag, " res_valid held"}, 64'(bus_if.res_valid), 64'd1);
        chk({tag, " sum_out stable"}, 64'({bus_if.cout, bus_if.sum_out}), 64'(exp));
        chk({tag, " start_ready held low"}, 64'(bus_if.start_ready), 64'd0);
      end
      bus_if.res_ready = 1'b1;
      tick();
      chk({tag, " res_valid after handoff"}, 64'(bus_if.res_valid), 64'd0);
      chk({tag, " start_ready after handoff"}, 64'(bus_if.start_ready), 64'd1);
      chk({tag, " busy after handoff"}, 64'(busy), 64'd0);
      chk({tag, " result retained"}, 64'({bus_if.cout, bus_if.sum_out}), 64'(exp));
    end
    bus_if.res_ready = 1'b0;
  endtask

  // Idle for a while and confirm no result ever appears
  task automatic no_phantom(input string tag);
    bit any;
    any = 1'b0;
    for (int i = 0; i < 3 * int'(WIDTH); i++) begin
      tick();
      if (bus_if.res_valid) any = 1'b1;
    end
    chk({tag, " no phantom result"}, 64'(any), 64'd0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    rst                = 1'b1;
    bus_if.start_valid = 1'b0;
    bus_if.res_ready   = 1'b0;
    bus_if.a_in        = '0;
    bus_if.b_in        = '0;
    bus_if.cin         = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset res_valid", 64'(bus_if.res_valid), 64'd0);
    chk("reset sum_out", 64'(bus_if.sum_out), 64'd0);
    chk("reset cout", 64'(bus_if.cout), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset start_ready", 64'(bus_if.start_ready), 64'd1);

    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ripple");
    run_op(8'h5A, 8'h3C, 1'b1, 0, 1'b0, "mixed");
    run_op(8'hFF, 8'hFF, 1'b1, 1, 1'b0, "allones");

    run_op(8'h12, 8'h34, 1'b0, 5, 1'b1, "backpressure");
    no_phantom("backpressure");

    bus_if.start_valid = 1'b1;
    bus_if.a_in        = 8'hAA;
    bus_if.b_in        = 8'h55;
    bus_if.cin         = 1'b0;
    tick();
    bus_if.start_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrun busy before reset", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun busy", 64'(busy), 64'd0);
    chk("midrun res_valid", 64'(bus_if.res_valid), 64'd0);
    chk("midrun sum_out", 64'(bus_if.sum_out), 64'd0);
    chk("midrun cout", 64'(bus_if.cout), 64'd0);
    chk("midrun start_ready", 64'(bus_if.start_ready), 64'd1);
    no_phantom("midrun");
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, "after reset");

    rst                = 1'b1;
    bus_if.start_valid = 1'b1;
    bus_if.a_in        = 8'h11;
    bus_if.b_in        = 8'h22;
    tick();
    rst                = 1'b0;
    bus_if.start_valid = 1'b0;
    chk("rst vs start busy", 64'(busy), 64'd0);
    tick();
    chk("rst vs start still idle", 64'(busy), 64'd0);

    for (int k = 0; k < 25; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
